// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - timing descriptors and derived sync windows for vga_timing_gen
package vga_timing_pkg;

    localparam int TW = 16;

    typedef enum logic {
        MODE_A = 1'b0,
        MODE_B = 1'b1
    } mode_e;

    typedef struct packed {
        logic [TW-1:0] act;
        logic [TW-1:0] fp;
        logic [TW-1:0] sync;
        logic [TW-1:0] bp;
        logic          pol;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } video_mode_t;

    // Pre-summed boundaries so the per-pixel decode is only compares.
    typedef struct packed {
        logic [TW-1:0] act;
        logic [TW-1:0] sync_start;
        logic [TW-1:0] sync_end;
        logic [TW-1:0] total;
        logic          pol;
    } window_t;

    function automatic logic [TW-1:0] tot(timing_t t);
        return t.act + t.fp + t.sync + t.bp;
    endfunction

    function automatic window_t window(timing_t t);
        window_t w;
        w.act        = t.act;
        w.sync_start = t.act + t.fp;
        w.sync_end   = t.act + t.fp + t.sync;
        w.total      = tot(t);
        w.pol        = t.pol;
        return w;
    endfunction

    localparam video_mode_t VGA_640x480_60 = '{
        h: '{act: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48, pol: 1'b0},
        v: '{act: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33, pol: 1'b0}
    };

    localparam video_mode_t SVGA_800x600_60 = '{
        h: '{act: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88, pol: 1'b1},
        v: '{act: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23, pol: 1'b1}
    };

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping axis counter with runtime total, exports the next count
module vga_axis_counter #(
    parameter int               CORDW = 11,
    parameter logic [CORDW-1:0] LOAD  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CORDW-1:0] total_i,
    output logic [CORDW-1:0] count_o,
    output logic             wrap_o
);

    logic [CORDW-1:0] count_q;
    logic [CORDW-1:0] count_d;

    // count_o is the value the register takes at the next edge, so the
    // parent can register its decode in the same cycle as the count.
    always_comb begin
        wrap_o  = en_i && (count_q >= total_i - CORDW'(1));
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CORDW'(1);
        end
    end

    assign count_o = count_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - dual-mode VGA/DVI timing generator with frame-boundary mode switch
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CORDW    = 11,
    parameter int   H_ACT_A  = int'(VGA_640x480_60.h.act),
    parameter int   H_FP_A   = int'(VGA_640x480_60.h.fp),
    parameter int   H_SYNC_A = int'(VGA_640x480_60.h.sync),
    parameter int   H_BP_A   = int'(VGA_640x480_60.h.bp),
    parameter int   V_ACT_A  = int'(VGA_640x480_60.v.act),
    parameter int   V_FP_A   = int'(VGA_640x480_60.v.fp),
    parameter int   V_SYNC_A = int'(VGA_640x480_60.v.sync),
    parameter int   V_BP_A   = int'(VGA_640x480_60.v.bp),
    parameter logic H_POL_A  = VGA_640x480_60.h.pol,
    parameter logic V_POL_A  = VGA_640x480_60.v.pol,
    parameter int   H_ACT_B  = int'(SVGA_800x600_60.h.act),
    parameter int   H_FP_B   = int'(SVGA_800x600_60.h.fp),
    parameter int   H_SYNC_B = int'(SVGA_800x600_60.h.sync),
    parameter int   H_BP_B   = int'(SVGA_800x600_60.h.bp),
    parameter int   V_ACT_B  = int'(SVGA_800x600_60.v.act),
    parameter int   V_FP_B   = int'(SVGA_800x600_60.v.fp),
    parameter int   V_SYNC_B = int'(SVGA_800x600_60.v.sync),
    parameter int   V_BP_B   = int'(SVGA_800x600_60.v.bp),
    parameter logic H_POL_B  = SVGA_800x600_60.h.pol,
    parameter logic V_POL_B  = SVGA_800x600_60.v.pol
) (
    input  logic             i_VGA_CLOCK,
    input  logic             i_rst_n,
    input  logic             i_mode,
    output logic             o_mode,
    output logic [CORDW-1:0] o_Sx,
    output logic [CORDW-1:0] o_Sy,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_line_start,
    output logic             o_frame_start
);

    localparam timing_t TH_A = '{act: TW'(H_ACT_A), fp: TW'(H_FP_A), sync: TW'(H_SYNC_A),
                                 bp: TW'(H_BP_A), pol: H_POL_A};
    localparam timing_t TV_A = '{act: TW'(V_ACT_A), fp: TW'(V_FP_A), sync: TW'(V_SYNC_A),
                                 bp: TW'(V_BP_A), pol: V_POL_A};
    localparam timing_t TH_B = '{act: TW'(H_ACT_B), fp: TW'(H_FP_B), sync: TW'(H_SYNC_B),
                                 bp: TW'(H_BP_B), pol: H_POL_B};
    localparam timing_t TV_B = '{act: TW'(V_ACT_B), fp: TW'(V_FP_B), sync: TW'(V_SYNC_B),
                                 bp: TW'(V_BP_B), pol: V_POL_B};

    localparam window_t WH_A = window(TH_A);
    localparam window_t WV_A = window(TV_A);
    localparam window_t WH_B = window(TH_B);
    localparam window_t WV_B = window(TV_B);

    localparam int TOT_MAX_A = (int'(WH_A.total) > int'(WV_A.total)) ? int'(WH_A.total) : int'(WV_A.total);
    localparam int TOT_MAX_B = (int'(WH_B.total) > int'(WV_B.total)) ? int'(WH_B.total) : int'(WV_B.total);
    localparam int TOT_MAX   = (TOT_MAX_A > TOT_MAX_B) ? TOT_MAX_A : TOT_MAX_B;

    generate
        if (CORDW >= 31 || TOT_MAX - 1 >= (1 << CORDW)) begin : g_cordw_check
            $error("vga_timing_gen: CORDW cannot hold max(H_TOT, V_TOT)-1");
        end
    endgenerate

    mode_e            mode_q;
    mode_e            mode_d;
    logic             first_q;
    window_t          wh_cur;
    window_t          wv_cur;
    window_t          wh_nxt;
    window_t          wv_nxt;
    logic [CORDW-1:0] h_d;
    logic [CORDW-1:0] v_d;
    logic             h_wrap;
    logic             v_wrap;

    logic [CORDW-1:0] sx_q;
    logic [CORDW-1:0] sy_q;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;

    assign wh_cur = (mode_q == MODE_B) ? WH_B : WH_A;
    assign wv_cur = (mode_q == MODE_B) ? WV_B : WV_A;

    vga_axis_counter #(
        .CORDW (CORDW),
        .LOAD  (CORDW'(WH_A.total - TW'(1)))
    ) u_h_cnt (
        .clk_i   (i_VGA_CLOCK),
        .rst_ni  (i_rst_n),
        .en_i    (1'b1),
        .total_i (CORDW'(wh_cur.total)),
        .count_o (h_d),
        .wrap_o  (h_wrap)
    );

    vga_axis_counter #(
        .CORDW (CORDW),
        .LOAD  (CORDW'(WV_A.total - TW'(1)))
    ) u_v_cnt (
        .clk_i   (i_VGA_CLOCK),
        .rst_ni  (i_rst_n),
        .en_i    (h_wrap),
        .total_i (CORDW'(wv_cur.total)),
        .count_o (v_d),
        .wrap_o  (v_wrap)
    );

    // The reset state sits on the frame boundary; the first edge after
    // release must not sample i_mode so restart is always in mode A.
    always_comb begin
        mode_d = mode_q;
        if (h_wrap && v_wrap && !first_q) begin
            mode_d = mode_e'(i_mode);
        end
    end

    assign wh_nxt = (mode_d == MODE_B) ? WH_B : WH_A;
    assign wv_nxt = (mode_d == MODE_B) ? WV_B : WV_A;

    always_comb begin
        de_d = (h_d < CORDW'(wh_nxt.act)) && (v_d < CORDW'(wv_nxt.act));
        hs_d = ((h_d >= CORDW'(wh_nxt.sync_start)) && (h_d < CORDW'(wh_nxt.sync_end)))
               ? wh_nxt.pol : ~wh_nxt.pol;
        vs_d = ((v_d >= CORDW'(wv_nxt.sync_start)) && (v_d < CORDW'(wv_nxt.sync_end)))
               ? wv_nxt.pol : ~wv_nxt.pol;
        ls_d = (h_d == '0);
        fs_d = (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            first_q <= 1'b1;
            mode_q  <= MODE_A;
            sx_q    <= '0;
            sy_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~WH_A.pol;
            vs_q    <= ~WV_A.pol;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            first_q <= 1'b0;
            mode_q  <= mode_d;
            sx_q    <= h_d;
            sy_q    <= v_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign o_mode        = mode_q;
    assign o_Sx          = sx_q;
    assign o_Sy          = sy_q;
    assign o_de          = de_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen with reduced timing sets
module tb_vga_timing_gen;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        mode_in = 1'b0;
    logic        o_mode;
    logic [10:0] o_Sx;
    logic [10:0] o_Sy;
    logic        o_de;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_line_start;
    logic        o_frame_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Mode A: H 8/2/3/3 (16), V 4/1/2/2 (9), active-low syncs.
    // Mode B: H 10/1/4/2 (17), V 5/1/1/3 (10), active-high syncs.
    vga_timing_gen #(
        .CORDW(11),
        .H_ACT_A(8),  .H_FP_A(2), .H_SYNC_A(3), .H_BP_A(3),
        .V_ACT_A(4),  .V_FP_A(1), .V_SYNC_A(2), .V_BP_A(2),
        .H_POL_A(1'b0), .V_POL_A(1'b0),
        .H_ACT_B(10), .H_FP_B(1), .H_SYNC_B(4), .H_BP_B(2),
        .V_ACT_B(5),  .V_FP_B(1), .V_SYNC_B(1), .V_BP_B(3),
        .H_POL_B(1'b1), .V_POL_B(1'b1)
    ) dut (
        .i_VGA_CLOCK   (clk),
        .i_rst_n       (rst_n),
        .i_mode        (mode_in),
        .o_mode        (o_mode),
        .o_Sx          (o_Sx),
        .o_Sy          (o_Sy),
        .o_de          (o_de),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_line_start  (o_line_start),
        .o_frame_start (o_frame_start)
    );

    typedef struct packed {
        logic [10:0] sx;
        logic [10:0] sy;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        md;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t model_out(int x, int y, logic m);
        exp_t e;
        int ha, hf, hw, va, vf, vw;
        logic hp, vp;
        if (m) begin
            ha = 10; hf = 1; hw = 4; va = 5; vf = 1; vw = 1; hp = 1'b1; vp = 1'b1;
        end else begin
            ha = 8;  hf = 2; hw = 3; va = 4; vf = 1; vw = 2; hp = 1'b0; vp = 1'b0;
        end
        e.sx = 11'(x);
        e.sy = 11'(y);
        e.de = (x < ha) && (y < va);
        e.hs = (x >= ha + hf && x < ha + hf + hw) ? hp : ~hp;
        e.vs = (y >= va + vf && y < va + vf + vw) ? vp : ~vp;
        e.ls = (x == 0);
        e.fs = (x == 0) && (y == 0);
        e.md = m;
        return e;
    endfunction

    // Reference pixel walker: one expected output per active clock edge.
    initial begin
        int   mx;
        int   my;
        logic mm;
        bit   mfirst;
        mx = 0; my = 0; mm = 1'b0; mfirst = 1'b1;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mfirst = 1'b1;
            end else begin
                if (mfirst) begin
                    mx = 0; my = 0; mm = 1'b0; mfirst = 1'b0;
                end else begin
                    mx++;
                    if (mx == (mm ? 17 : 16)) begin
                        mx = 0;
                        my++;
                        if (my == (mm ? 10 : 9)) begin
                            my = 0;
                            mm = mode_in;
                        end
                    end
                end
                exp_q.push_back(model_out(mx, my, mm));
            end
        end
    end

    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{sx: o_Sx, sy: o_Sy, de: o_de, hs: o_hsync, vs: o_vsync,
                      ls: o_line_start, fs: o_frame_start, md: o_mode};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b md=%b required sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b md=%b",
                             $time, g.sx, g.sy, g.de, g.hs, g.vs, g.ls, g.fs, g.md,
                             e.sx, e.sy, e.de, e.hs, e.vs, e.ls, e.fs, e.md);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sx"},   32'(o_Sx), 0);
        check({tag, "_sy"},   32'(o_Sy), 0);
        check({tag, "_de"},   32'(o_de), 0);
        check({tag, "_ls"},   32'(o_line_start), 0);
        check({tag, "_fs"},   32'(o_frame_start), 0);
        check({tag, "_mode"}, 32'(o_mode), 0);
        check({tag, "_hs"},   32'(o_hsync), 1);
        check({tag, "_vs"},   32'(o_vsync), 1);
    endtask

    task automatic wait_xy(input int x, input int y, input int maxc);
        int   n;
        logic hit;
        n = 0; hit = 1'b0;
        while (!hit && n < maxc) begin
            @(posedge clk); #1;
            n++;
            hit = (int'(o_Sx) == x) && (int'(o_Sy) == y);
        end
        check("wait_xy_reached", 32'(hit), 1);
    endtask

    task automatic wait_fs(input int maxc);
        int   n;
        logic hit;
        n = 0; hit = 1'b0;
        while (!hit && n < maxc) begin
            @(posedge clk); #1;
            n++;
            hit = o_frame_start;
        end
        check("wait_fs_reached", 32'(hit), 1);
    endtask

    // Called while sitting on a frame_start pixel; walks to the next one.
    task automatic scan_frame(output int n, output int de_n, output int hs_n,
                              output int vs_n, output int hmin, output int hmax);
        n = 0; de_n = 0; hs_n = 0; vs_n = 0; hmin = 9999; hmax = -1;
        do begin
            if (o_de) de_n++;
            if (o_hsync == o_mode) begin
                hs_n++;
                if (int'(o_Sx) < hmin) hmin = int'(o_Sx);
                if (int'(o_Sx) > hmax) hmax = int'(o_Sx);
            end
            if (o_vsync == o_mode) vs_n++;
            n++;
            @(posedge clk); #1;
        end while (!o_frame_start && n < 1000);
    endtask

    initial begin
        int n, de_n, hs_n, vs_n, hmin, hmax;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_sx", 32'(o_Sx), 0);
        check("first_sy", 32'(o_Sy), 0);
        check("first_de", 32'(o_de), 1);
        check("first_ls", 32'(o_line_start), 1);
        check("first_fs", 32'(o_frame_start), 1);
        check("first_mode", 32'(o_mode), 0);

        scan_frame(n, de_n, hs_n, vs_n, hmin, hmax);
        check("a_period", n, 144);
        check("a_de_count", de_n, 32);
        check("a_hs_count", hs_n, 27);
        check("a_vs_count", vs_n, 32);
        check("a_hs_first", hmin, 10);
        check("a_hs_last", hmax, 12);

        wait_xy(0, 3, 200);
        @(negedge clk) mode_in = 1'b1;
        wait_xy(15, 8, 200);
        check("switch_held_mode", 32'(o_mode), 0);
        @(posedge clk); #1;
        check("switch_fs", 32'(o_frame_start), 1);
        check("switch_mode", 32'(o_mode), 1);
        check("switch_hs_idle", 32'(o_hsync), 0);
        check("switch_vs_idle", 32'(o_vsync), 0);

        scan_frame(n, de_n, hs_n, vs_n, hmin, hmax);
        check("b_period", n, 170);
        check("b_de_count", de_n, 50);
        check("b_hs_count", hs_n, 40);
        check("b_vs_count", vs_n, 17);
        check("b_hs_first", hmin, 11);
        check("b_hs_last", hmax, 14);
        check("b_still_b", 32'(o_mode), 1);

        wait_xy(0, 2, 300);
        @(negedge clk) mode_in = 1'b0;
        wait_xy(0, 4, 300);
        @(negedge clk) mode_in = 1'b1;
        wait_xy(0, 6, 300);
        @(negedge clk) mode_in = 1'b0;
        wait_fs(300);
        check("glitch_to_a_mode", 32'(o_mode), 0);
        check("glitch_to_a_hs", 32'(o_hsync), 1);
        check("glitch_to_a_vs", 32'(o_vsync), 1);

        wait_xy(0, 2, 300);
        @(negedge clk) mode_in = 1'b1;
        wait_xy(0, 5, 300);
        @(negedge clk) mode_in = 1'b0;
        wait_fs(300);
        check("transient_ignored", 32'(o_mode), 0);

        @(negedge clk) mode_in = 1'b1;
        wait_fs(300);
        check("to_b_again", 32'(o_mode), 1);
        wait_xy(7, 4, 300);
        check("pre_reset_de", 32'(o_de), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset("async");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_sx", 32'(o_Sx), 0);
        check("restart_sy", 32'(o_Sy), 0);
        check("restart_fs", 32'(o_frame_start), 1);
        check("restart_mode", 32'(o_mode), 0);

        scan_frame(n, de_n, hs_n, vs_n, hmin, hmax);
        check("restart_period", n, 144);
        check("restart_next_mode", 32'(o_mode), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised, dual-mode VGA/DVI timing generator; next generation of the fixed 640x480 core.
- Produces pixel coordinates, draw-enable, polarity-configurable H/V sync, and line/frame start strobes.
- Supports two timing sets (A, B), switchable at run time only on a frame boundary.
- Sits between the pixel clock domain and the framebuffer/pattern pipeline; all outputs are registered and mutually aligned.

Parameters:
- CORDW, 11, coordinate/counter width; must hold max(H_TOT, V_TOT)-1 (elaboration-time assertion).
- H_ACT_A/H_FP_A/H_SYNC_A/H_BP_A, 640/16/96/48, mode A horizontal timing in pixels.
- V_ACT_A/V_FP_A/V_SYNC_A/V_BP_A, 480/10/2/33, mode A vertical timing in lines.
- H_POL_A/V_POL_A, 0/0, mode A sync polarity (1 = active-high).
- H_ACT_B/H_FP_B/H_SYNC_B/H_BP_B, 800/40/128/88, mode B horizontal timing.
- V_ACT_B/V_FP_B/V_SYNC_B/V_BP_B, 600/1/4/23, mode B vertical timing.
- H_POL_B/V_POL_B, 1/1, mode B sync polarity.

Ports:
- i_VGA_CLOCK  in  1  pixel clock; sole clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mode  in  1  requested mode (0 = A, 1 = B); may change at any time.
- o_mode  out  1  mode in effect for the current output pixel.
- o_Sx  out  CORDW  horizontal coordinate; 0 = first active pixel.
- o_Sy  out  CORDW  vertical coordinate; 0 = first active line.
- o_de  out  1  draw enable; high only when the pixel is active.
- o_hsync  out  1  horizontal sync at the mode's polarity.
- o_vsync  out  1  vertical sync at the mode's polarity.
- o_line_start  out  1  one-cycle strobe at o_Sx==0.
- o_frame_start  out  1  one-cycle strobe at o_Sx==0 && o_Sy==0.

Behaviour:
- Line order: active, front porch, sync, back porch. H_TOT = ACT+FP+SYNC+BP, same for vertical.
- Internal H counter runs 0..H_TOT-1 and wraps. The V counter increments when H wraps, 0..V_TOT-1, and wraps.
- Reset (async assert, release synchronous to clock):
  - Internal counters = (H_TOT_A-1, V_TOT_A-1); active mode = A.
  - Outputs: o_Sx=0, o_Sy=0, o_de=0, o_line_start=0, o_frame_start=0, o_mode=0.
  - o_hsync/o_vsync = inactive level of mode A (~H_POL_A / ~V_POL_A).
- First rising edge after release: outputs present pixel (0,0): o_de=1, both strobes=1.
- Outputs are registered from the next-counter value. Latency 0 between coordinates and their decode: in every cycle, o_de/o_*sync/strobes/o_mode describe exactly (o_Sx,o_Sy).
- o_de = (Sx < ACT_H) && (Sy < ACT_V).
- Sync assertion windows (sync driven to POL inside the window, ~POL outside):
  - hsync: ACT_H+FP_H <= Sx < ACT_H+FP_H+SYNC_H.
  - vsync: ACT_V+FP_V <= Sy < ACT_V+FP_V+SYNC_V, applied to whole lines.
- Mode switching:
  - i_mode is sampled only on the transition from (H_TOT-1, V_TOT-1) to (0,0).
  - The new mode's timing, polarity and o_mode take effect at the pixel carrying o_frame_start.
  - Mid-frame toggles of i_mode are ignored; only the value at the boundary cycle matters.
  - When the mode changes, the syncs switch to the new polarity's inactive level in the same cycle.
- Comparisons use CORDW-bit unsigned arithmetic; no counter ever exceeds its TOT-1.
- Async reset mid-frame: all outputs go to reset values immediately. Restart is always in mode A at (0,0).

Decomposition:
- Package vga_timing_pkg:
  - typedef struct timing_t {act, fp, sync, bp, pol}.
  - Function tot(timing_t).
  - Constants VGA_640x480_60 and SVGA_800x600_60.
- Sub-module vga_axis_counter (instantiated twice for H and V):
  - Inputs: enable, runtime total.
  - Outputs: count, wrap flag.
  - Asynchronous reset to a load value.

Test Plan:
- Reset release, mode A: first edge gives o_Sx=0, o_Sy=0, o_de=1, both strobes 1. o_Sx reaches 799 then 0 with o_Sy=1. Frame period = 800*525 = 420000 cycles.
- Mode A decode: o_de falls at o_Sx=640. o_hsync low for o_Sx 656..751 (96 cycles). o_vsync low for o_Sy 490..491. o_de low for every o_Sy >= 480.
- Switch to B: i_mode=1 driven at o_Sy=100. No change until the frame wraps. At the next o_frame_start, o_mode=1 and o_hsync/o_vsync are idle low. o_hsync is high for o_Sx 840..967. Frame period = 1056*628 cycles.
- Glitchy i_mode: toggle i_mode 1→0→1 mid-frame, leaving 0 during the boundary cycle. The mode stays/becomes A; the transient is ignored.
- Async reset mid-frame in mode B at (500,300): outputs return to reset values without a clock edge. The next frame starts in mode A at (0,0).
- Alignment check: across a full frame in both modes, o_line_start==(o_Sx==0) and o_frame_start==(o_Sx==0&&o_Sy==0) every cycle.
